// File: rtl/mp3_huff_pkg.sv
// Shared MP3 Huffman definitions: table-1 codebook entries and encoder FSM states.
// The table-1 constants are reused by the matching bit-serial decoder.
package mp3_huff_pkg;

    localparam int unsigned HT_MAX_CODE_BITS = 3;
    localparam int unsigned HT_VAL_WIDTH     = 4;

    typedef struct packed {
        logic [HT_MAX_CODE_BITS-1:0] code;
        logic [1:0]                  len;
    } ht_entry_t;

    // Codewords are right-aligned in the code field; len gives how many LSBs are live.
    localparam ht_entry_t HT1_X0_Y0 = '{code: 3'b001, len: 2'd1};
    localparam ht_entry_t HT1_X1_Y0 = '{code: 3'b001, len: 2'd2};
    localparam ht_entry_t HT1_X0_Y1 = '{code: 3'b001, len: 2'd3};
    localparam ht_entry_t HT1_X1_Y1 = '{code: 3'b000, len: 2'd3};

    typedef enum logic {
        IDLE,
        SHIFT
    } enc_state_t;

    function automatic ht_entry_t ht1_lookup(input logic x, input logic y);
        ht_entry_t e;
        unique case ({x, y})
            2'b00:   e = HT1_X0_Y0;
            2'b10:   e = HT1_X1_Y0;
            2'b01:   e = HT1_X0_Y1;
            default: e = HT1_X1_Y1;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/ht1_encoder_if.sv
// Pair-in / bit-out stream bundle of the table-1 encoder.
// slave is the encoder side, master the producer/consumer side.
interface ht1_encoder_if #(
    parameter int unsigned VAL_WIDTH = 4
);
    logic                 axiiv;
    logic                 axiir;
    logic [VAL_WIDTH-1:0] x_val;
    logic [VAL_WIDTH-1:0] y_val;
    logic                 x_sign;
    logic                 y_sign;
    logic                 axiov;
    logic                 axiod;
    logic                 axior;

    modport master (
        output axiiv, x_val, y_val, x_sign, y_sign, axior,
        input  axiir, axiov, axiod
    );

    modport slave (
        input  axiiv, x_val, y_val, x_sign, y_sign, axior,
        output axiir, axiov, axiod
    );
endinterface

// File: rtl/ht1_code_lut.sv
// Combinational table-1 lookup: (x,y) magnitudes -> legality flag and codeword entry.
module ht1_code_lut
    import mp3_huff_pkg::*;
#(
    parameter int unsigned VAL_WIDTH = HT_VAL_WIDTH
) (
    input  logic [VAL_WIDTH-1:0] x_val_i,
    input  logic [VAL_WIDTH-1:0] y_val_i,
    output logic                 legal_o,
    output ht_entry_t            entry_o
);

    always_comb begin
        legal_o = (x_val_i <= VAL_WIDTH'(1)) && (y_val_i <= VAL_WIDTH'(1));
        entry_o = ht1_lookup(x_val_i[0], y_val_i[0]);
    end

endmodule

// File: rtl/ht1_encoder.sv
// MP3 table-1 Huffman encoder: accepts one (x,y) pair with signs and shifts the
// codeword plus sign bits out MSB-first, one bit per cycle, with valid/ready on both sides.
module ht1_encoder
    import mp3_huff_pkg::*;
#(
    parameter int unsigned MAX_CODE_BITS = HT_MAX_CODE_BITS,
    parameter int unsigned VAL_WIDTH     = HT_VAL_WIDTH,
    parameter int unsigned EMIT_SIGNS    = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    ht1_encoder_if.slave  bus,
    output logic          err,
    output logic          busy
);

    localparam int unsigned SymBits = MAX_CODE_BITS + 2;

    enc_state_t          state_q, state_d;
    logic [SymBits-1:0]  sym_sr_q, sym_sr_d;
    logic [2:0]          sym_len_q, sym_len_d;
    logic                err_q, err_d;

    logic                lut_legal;
    ht_entry_t           lut_entry;
    logic [SymBits-1:0]  sym_raw;
    logic [SymBits-1:0]  sym_new;
    logic [2:0]          sym_n;
    logic                last_bit;
    logic                ready;
    logic                accept;

    ht1_code_lut #(
        .VAL_WIDTH (VAL_WIDTH)
    ) u_lut (
        .x_val_i (bus.x_val),
        .y_val_i (bus.y_val),
        .legal_o (lut_legal),
        .entry_o (lut_entry)
    );

    // Symbol builder: append signs of nonzero values, then left-align into the shifter.
    always_comb begin
        sym_raw = SymBits'(lut_entry.code);
        sym_n   = {1'b0, lut_entry.len};
        if (EMIT_SIGNS != 0) begin
            if (bus.x_val != '0) begin
                sym_raw = {sym_raw[SymBits-2:0], bus.x_sign};
                sym_n   = sym_n + 3'd1;
            end
            if (bus.y_val != '0) begin
                sym_raw = {sym_raw[SymBits-2:0], bus.y_sign};
                sym_n   = sym_n + 3'd1;
            end
        end
        sym_new = sym_raw << (3'(SymBits) - sym_n);
    end

    always_comb begin
        state_d   = state_q;
        sym_sr_d  = sym_sr_q;
        sym_len_d = sym_len_q;
        err_d     = 1'b0;

        last_bit  = (sym_len_q == 3'd1);
        // Ready on the last handshaken bit lets the next symbol load with no bubble.
        ready     = (state_q == IDLE) || ((state_q == SHIFT) && last_bit && bus.axior);
        accept    = bus.axiiv && ready;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (lut_legal) begin
                        state_d   = SHIFT;
                        sym_sr_d  = sym_new;
                        sym_len_d = sym_n;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (bus.axior) begin
                    sym_sr_d  = sym_sr_q << 1;
                    sym_len_d = sym_len_q - 3'd1;
                    if (last_bit) begin
                        state_d = IDLE;
                        if (accept) begin
                            if (lut_legal) begin
                                state_d   = SHIFT;
                                sym_sr_d  = sym_new;
                                sym_len_d = sym_n;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        bus.axiir = ready;
        bus.axiov = (state_q == SHIFT);
        bus.axiod = (state_q == SHIFT) && sym_sr_q[SymBits-1];
        err       = err_q;
        busy      = (state_q == SHIFT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sym_sr_q  <= '0;
            sym_len_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sym_sr_q  <= sym_sr_d;
            sym_len_q <= sym_len_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_ht1_encoder.sv
// Randomized self-checking bench for ht1_encoder: a sign-emitting and a codeword-only
// instance are checked against a codebook model and a behavioural table-1 decoder.
module tb_ht1_encoder;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
        logic       xs;
        logic       ys;
    } pair_t;

    localparam int Limit = 30000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ht1_encoder_if #(.VAL_WIDTH(4)) ifs ();
    ht1_encoder_if #(.VAL_WIDTH(4)) ifn ();

    logic err_s, busy_s, err_n, busy_n;
    logic sel = 1'b0;  // 0: sign-emitting instance, 1: codeword-only instance
    logic drv_v = 1'b0, drv_r = 1'b0, drv_xs = 1'b0, drv_ys = 1'b0;
    logic [3:0] drv_x = '0, drv_y = '0;

    assign ifs.axiiv  = drv_v & ~sel;
    assign ifn.axiiv  = drv_v & sel;
    assign ifs.axior  = drv_r & ~sel;
    assign ifn.axior  = drv_r & sel;
    assign ifs.x_val  = drv_x;
    assign ifn.x_val  = drv_x;
    assign ifs.y_val  = drv_y;
    assign ifn.y_val  = drv_y;
    assign ifs.x_sign = drv_xs;
    assign ifn.x_sign = drv_xs;
    assign ifs.y_sign = drv_ys;
    assign ifn.y_sign = drv_ys;

    logic mon_ov, mon_od, mon_ir, mon_err, mon_busy;
    assign mon_ov   = sel ? ifn.axiov : ifs.axiov;
    assign mon_od   = sel ? ifn.axiod : ifs.axiod;
    assign mon_ir   = sel ? ifn.axiir : ifs.axiir;
    assign mon_err  = sel ? err_n : err_s;
    assign mon_busy = sel ? busy_n : busy_s;

    ht1_encoder #(.MAX_CODE_BITS(3), .VAL_WIDTH(4), .EMIT_SIGNS(1)) u_dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifs.slave),
        .err   (err_s),
        .busy  (busy_s)
    );

    ht1_encoder #(.MAX_CODE_BITS(3), .VAL_WIDTH(4), .EMIT_SIGNS(0)) u_dut_n (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifn.slave),
        .err   (err_n),
        .busy  (busy_n)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic exp_q[$];
    logic out_q[$];
    logic ir_q[$];
    int   bitcyc_q[$];
    int   err_obs_q[$];
    int   err_exp_q[$];
    int   stall_viol = 0;
    bit   stall_pend = 0;
    logic stall_bit = 1'b0;
    logic last_busy = 1'b0;
    int   ir_busy_cnt = 0;

    function automatic pair_t mk(input int x, input int y, input bit xs, input bit ys);
        pair_t p;
        p.x = 4'(x);
        p.y = 4'(y);
        p.xs = xs;
        p.ys = ys;
        return p;
    endfunction

    function automatic pair_t rand_legal();
        return mk($urandom_range(1), $urandom_range(1), 1'($urandom_range(1)),
                  1'($urandom_range(1)));
    endfunction

    // Reference: codebook (0,0)->1, (1,0)->01, (0,1)->001, (1,1)->000, then signs.
    task automatic add_expected(input pair_t p, input bit emit);
        if (p.x == 0 && p.y == 0) begin
            exp_q.push_back(1'b1);
        end else if (p.x == 1 && p.y == 0) begin
            exp_q.push_back(1'b0); exp_q.push_back(1'b1);
        end else if (p.x == 0 && p.y == 1) begin
            exp_q.push_back(1'b0); exp_q.push_back(1'b0); exp_q.push_back(1'b1);
        end else begin
            exp_q.push_back(1'b0); exp_q.push_back(1'b0); exp_q.push_back(1'b0);
        end
        if (emit && p.x != 0) exp_q.push_back(p.xs);
        if (emit && p.y != 0) exp_q.push_back(p.ys);
    endtask

    task automatic clear_logs();
        exp_q.delete(); out_q.delete(); ir_q.delete(); bitcyc_q.delete();
        err_obs_q.delete(); err_exp_q.delete();
        stall_viol = 0; stall_pend = 0; ir_busy_cnt = 0;
    endtask

    // Called at a negedge with inputs driven; samples mid-cycle, returns at next negedge.
    task automatic tick(output bit acc);
        #1;
        cyc++;
        acc = (drv_v && mon_ir === 1'b1);
        last_busy = mon_busy;
        if (mon_err === 1'b1) err_obs_q.push_back(cyc);
        if (stall_pend && (mon_ov !== 1'b1 || mon_od !== stall_bit)) stall_viol++;
        stall_pend = (mon_ov === 1'b1) && !drv_r;
        stall_bit = mon_od;
        if (mon_ov === 1'b1 && drv_r) begin
            out_q.push_back(mon_od);
            ir_q.push_back(mon_ir);
            bitcyc_q.push_back(cyc);
        end
        if (mon_busy === 1'b1 && mon_ir === 1'b1) ir_busy_cnt++;
        @(negedge clk);
    endtask

    task automatic send_pairs(input pair_t pq[$], input int rdy_pct, input int gap_pct,
                              input bit emit);
        int idx = 0;
        int guard = 0;
        bit acc;
        drv_v = 1'b0;
        while (idx < pq.size() && guard < Limit) begin
            if (!drv_v) drv_v = ($urandom_range(99) >= gap_pct);
            drv_x = pq[idx].x; drv_y = pq[idx].y;
            drv_xs = pq[idx].xs; drv_ys = pq[idx].ys;
            drv_r = ($urandom_range(99) < rdy_pct);
            tick(acc);
            guard++;
            if (acc) begin
                if (pq[idx].x <= 1 && pq[idx].y <= 1) add_expected(pq[idx], emit);
                else err_exp_q.push_back(cyc + 1);
                idx++;
                drv_v = 1'b0;
            end
        end
        drv_v = 1'b0;
        do begin
            drv_r = ($urandom_range(99) < rdy_pct);
            tick(acc);
            guard++;
        end while (last_busy === 1'b1 && guard < Limit);
        checks++;
        if (guard >= Limit) begin
            errors++;
            $display("FAIL send_pairs_timeout: accepted %0d of %0d pairs, busy=%b, bound %0d",
                     idx, pq.size(), last_busy, Limit);
        end
    endtask

    task automatic test_reset();
        bit acc;
        sel = 1'b0; drv_v = 1'b0; drv_r = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({ifs.axiov, ifs.axiod, ifs.axiir, err_s, busy_s} !== 5'b00100) begin
            errors++;
            $display("FAIL reset_state_s: {ov,od,ir,err,busy}=%b required 00100",
                     {ifs.axiov, ifs.axiod, ifs.axiir, err_s, busy_s});
        end
        checks++;
        if ({ifn.axiov, ifn.axiod, ifn.axiir, err_n, busy_n} !== 5'b00100) begin
            errors++;
            $display("FAIL reset_state_n: {ov,od,ir,err,busy}=%b required 00100",
                     {ifn.axiov, ifn.axiod, ifn.axiir, err_n, busy_n});
        end
        @(negedge clk);
        rst_n = 1'b1;
        clear_logs();
        drv_x = 4'd1; drv_y = 4'd1; drv_xs = 1'b1; drv_ys = 1'b0; drv_v = 1'b1;
        tick(acc);
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL reset_first_accept: accepted=%0b required 1", acc);
        end
        drv_v = 1'b0;
        tick(acc);
        #1;
        checks++;
        if (mon_busy !== 1'b1 || mon_ov !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_busy: busy=%b ov=%b required 1 1", mon_busy, mon_ov);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({mon_ov, mon_ir, mon_busy} !== 3'b010) begin
            errors++;
            $display("FAIL reset_mid_symbol: {ov,ir,busy}=%b required 010",
                     {mon_ov, mon_ir, mon_busy});
        end
        @(negedge clk);
        rst_n = 1'b1;
        clear_logs();
        repeat (10) tick(acc);
        checks++;
        if (out_q.size() != 0) begin
            errors++;
            $display("FAIL reset_no_stray_bits: got %0d bits required 0", out_q.size());
        end
    endtask

    task automatic test_codebook();
        pair_t pq[$];
        logic [8:0] got_bits = '0;
        logic [8:0] got_ir = '0;
        logic [8:0] want_bits = 9'b1_01_001_000;
        logic [8:0] want_ir = 9'b1_01_001_001;
        sel = 1'b1;
        clear_logs();
        pq = '{mk(0, 0, 1, 1), mk(1, 0, 1, 0), mk(0, 1, 0, 1), mk(1, 1, 1, 1)};
        send_pairs(pq, 100, 0, 1'b0);
        foreach (out_q[i]) begin
            got_bits = {got_bits[7:0], out_q[i]};
            got_ir = {got_ir[7:0], ir_q[i]};
        end
        checks++;
        if (out_q.size() != 9 || got_bits !== want_bits) begin
            errors++;
            $display("FAIL codebook_stream: %0d bits %b required 9 bits %b",
                     out_q.size(), got_bits, want_bits);
        end
        checks++;
        if (got_ir !== want_ir || ir_busy_cnt != 4) begin
            errors++;
            $display("FAIL codebook_ready: ir %b (%0d busy-ready cycles) required %b (4)",
                     got_ir, ir_busy_cnt, want_ir);
        end
        checks++;
        if (bitcyc_q.size() != 9 || bitcyc_q[bitcyc_q.size()-1] - bitcyc_q[0] != 8) begin
            errors++;
            $display("FAIL codebook_contiguous: %0d bits over %0d cycles required 9 over 9",
                     bitcyc_q.size(),
                     bitcyc_q.size() ? bitcyc_q[bitcyc_q.size()-1] - bitcyc_q[0] + 1 : 0);
        end
    endtask

    task automatic test_signs();
        pair_t cases[3];
        logic [4:0] want[3];
        int wlen[3];
        logic [4:0] got;
        pair_t one[$];
        cases[0] = mk(1, 1, 1, 0); want[0] = 5'b00010; wlen[0] = 5;
        cases[1] = mk(0, 1, 0, 1); want[1] = 5'b00011; wlen[1] = 4;
        cases[2] = mk(0, 0, 1, 1); want[2] = 5'b00001; wlen[2] = 1;
        sel = 1'b0;
        for (int k = 0; k < 3; k++) begin
            clear_logs();
            one = '{cases[k]};
            send_pairs(one, 100, 0, 1'b1);
            got = '0;
            foreach (out_q[i]) got = {got[3:0], out_q[i]};
            checks++;
            if (out_q.size() != wlen[k] || got !== want[k]) begin
                errors++;
                $display("FAIL signs_case%0d: %0d bits %b required %0d bits %b",
                         k, out_q.size(), got, wlen[k], want[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        pair_t pq[$];
        int mism = 0;
        sel = 1'b0;
        clear_logs();
        for (int i = 0; i < 200; i++) pq.push_back(rand_legal());
        send_pairs(pq, 50, 20, 1'b1);
        checks++;
        if (stall_viol != 0) begin
            errors++;
            $display("FAIL bp_stall_stable: %0d unstable stall cycles required 0", stall_viol);
        end
        foreach (exp_q[i]) if (i < out_q.size() && out_q[i] !== exp_q[i]) mism++;
        checks++;
        if (out_q.size() != exp_q.size() || mism != 0) begin
            errors++;
            $display("FAIL bp_stream: %0d bits (%0d wrong) required %0d bits (0 wrong)",
                     out_q.size(), mism, exp_q.size());
        end
        checks++;
        if (err_obs_q.size() != 0) begin
            errors++;
            $display("FAIL bp_no_err: err pulses %0d required 0", err_obs_q.size());
        end
    endtask

    task automatic test_illegal();
        pair_t pq[$];
        logic [2:0] got = '0;
        int mism = 0;
        sel = 1'b0;
        clear_logs();
        pq = '{mk(2, 0, 1, 1), mk(1, 0, 1, 0)};
        send_pairs(pq, 100, 0, 1'b1);
        checks++;
        if (err_obs_q.size() != 1 || err_exp_q.size() != 1 || err_obs_q[0] != err_exp_q[0]) begin
            errors++;
            $display("FAIL illegal_idle_err: %0d pulses (first at %0d) required 1 at %0d",
                     err_obs_q.size(), err_obs_q.size() ? err_obs_q[0] : -1,
                     err_exp_q.size() ? err_exp_q[0] : -1);
        end
        foreach (out_q[i]) got = {got[1:0], out_q[i]};
        checks++;
        if (out_q.size() != 3 || got !== 3'b011) begin
            errors++;
            $display("FAIL illegal_idle_next: %0d bits %b required 3 bits 011",
                     out_q.size(), got);
        end
        clear_logs();
        pq = '{mk(1, 1, 0, 1), mk(3, 0, 0, 0), mk(0, 0, 0, 0)};
        send_pairs(pq, 100, 0, 1'b1);
        checks++;
        if (err_obs_q.size() != 1 || err_exp_q.size() != 1 || err_obs_q[0] != err_exp_q[0]) begin
            errors++;
            $display("FAIL illegal_b2b_err: %0d pulses (first at %0d) required 1 at %0d",
                     err_obs_q.size(), err_obs_q.size() ? err_obs_q[0] : -1,
                     err_exp_q.size() ? err_exp_q[0] : -1);
        end
        foreach (exp_q[i]) if (i < out_q.size() && out_q[i] !== exp_q[i]) mism++;
        checks++;
        if (out_q.size() != exp_q.size() || mism != 0) begin
            errors++;
            $display("FAIL illegal_b2b_stream: %0d bits (%0d wrong) required %0d bits",
                     out_q.size(), mism, exp_q.size());
        end
    endtask

    task automatic test_loopback();
        pair_t pq[$];
        pair_t dec_q[$];
        int i = 0;
        int derr = 0;
        int mism = 0;
        sel = 1'b1;
        clear_logs();
        for (int k = 0; k < 1000; k++) pq.push_back(rand_legal());
        send_pairs(pq, 80, 10, 1'b0);
        // Behavioural table-1 decoder walking the captured bit stream
        while (i < out_q.size()) begin
            if (out_q[i] === 1'b1) begin
                dec_q.push_back(mk(0, 0, 0, 0)); i += 1;
            end else if (i + 1 >= out_q.size()) begin
                derr++; break;
            end else if (out_q[i+1] === 1'b1) begin
                dec_q.push_back(mk(1, 0, 0, 0)); i += 2;
            end else if (i + 2 >= out_q.size()) begin
                derr++; break;
            end else if (out_q[i+2] === 1'b1) begin
                dec_q.push_back(mk(0, 1, 0, 0)); i += 3;
            end else begin
                dec_q.push_back(mk(1, 1, 0, 0)); i += 3;
            end
        end
        foreach (pq[k]) begin
            if (k >= dec_q.size() || dec_q[k].x !== pq[k].x || dec_q[k].y !== pq[k].y) mism++;
        end
        checks++;
        if (dec_q.size() != 1000 || mism != 0) begin
            errors++;
            $display("FAIL loopback_pairs: decoded %0d (%0d wrong) required 1000 (0 wrong)",
                     dec_q.size(), mism);
        end
        checks++;
        if (derr != 0 || err_obs_q.size() != 0) begin
            errors++;
            $display("FAIL loopback_err: decode errors %0d, err pulses %0d required 0 0",
                     derr, err_obs_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_codebook();
        test_signs();
        test_backpressure();
        test_illegal();
        test_loopback();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
